// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: word memory that samples read data at issue and returns it LATENCY cycles later.
module mem_resp_pipe #(
    parameter int DEPTH_W   = 10,
    parameter int LATENCY   = 4,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  pending
);
    logic [15:0]        mem [2**DEPTH_W];
    logic [15:0]        dat [LATENCY];
    logic [LATENCY-1:0] vld;
    logic [DEPTH_W-1:0] idx;
    logic               rd;
    logic               unused_addr;

    assign idx         = addr[DEPTH_W:1];
    assign rd          = enable && !wr;
    assign unused_addr = ^{addr[15:DEPTH_W+1], addr[0]};
    assign data_valid  = vld[LATENCY-1];
    assign data_out    = data_valid ? dat[LATENCY-1] : 16'h0000;

    always_ff @(posedge clk) begin
        if (enable && wr) mem[idx] <= data_in;
        dat[0] <= mem[idx];
        for (int i = 1; i < LATENCY; i++) dat[i] <= dat[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            pending <= '0;
        end else begin
            vld[0] <= rd;
            for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
            pending <= pending + 4'(rd) - 4'(vld[LATENCY-1]);
        end
    end
endmodule

// File: tb/tb_mem_resp_pipe.sv
// tb_mem_resp_pipe: scoreboard bench; expected reads queued at issue, compared every cycle.
module tb_mem_resp_pipe;
    localparam int DEPTH_W = 10;
    localparam int LATENCY = 4;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        enable = 0;
    logic        wr = 0;
    logic [15:0] addr = 0;
    logic [15:0] data_in = 0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;

    logic [15:0] ref_mem [2**DEPTH_W];
    exp_t        q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;

    mem_resp_pipe #(.DEPTH_W(DEPTH_W), .LATENCY(LATENCY), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .pending(pending)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        int n;
        if (mon_en) begin
            n = 0;
            foreach (q[i]) if (q[i].due - LATENCY < cyc) n++;
            check("pending", 16'(pending), 16'(n));
            if (q.size() > 0 && q[0].due == cyc) begin
                check("valid", 16'(data_valid), 16'd1);
                check("data", data_out, q[0].data);
                void'(q.pop_front());
            end else begin
                check("valid_idle", 16'(data_valid), 16'd0);
                check("dout_idle", data_out, 16'h0000);
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        enable = 1; wr = 1; addr = a; data_in = d;
        ref_mem[a[DEPTH_W:1]] = d;
    endtask

    task automatic do_read(input logic [15:0] a);
        exp_t e;
        @(posedge clk); #1;
        enable = 1; wr = 0; addr = a; data_in = $urandom;
        e.due = cyc + LATENCY;
        e.data = ref_mem[a[DEPTH_W:1]];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            enable = 0; wr = $urandom; addr = $urandom;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        enable = 0;
        #1 rst_n = 0;
        q.delete();
        #1;
        check("rst_dout", data_out, 16'h0000);
        check("rst_valid", 16'(data_valid), 16'd0);
        check("rst_pending", 16'(pending), 16'd0);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        #12;
        check("init_pending", 16'(pending), 16'd0);
        rst_n = 1;
        mon_en = 1;
        do_reset();
        idle(10);
        do_write(16'h0010, 16'hBEEF);
        do_read(16'h0010);
        idle(LATENCY + 2);
        do_write(16'h0000, 16'h1111);
        do_write(16'h0002, 16'h2222);
        do_write(16'h0004, 16'h3333);
        do_write(16'h0006, 16'h4444);
        for (int i = 0; i < 4; i++) do_read(16'(2 * i));
        idle(LATENCY + 2);
        do_write(16'h0020, 16'h00AA);
        idle(1);
        do_read(16'h0020);
        do_write(16'h0020, 16'h0055);
        do_read(16'h0020);
        idle(LATENCY + 2);
        do_write(16'h0802, 16'h1234);
        do_read(16'h0003);
        idle(2);
        do_read(16'h0003);
        idle(1);
        do_read(16'hF803);
        idle(LATENCY + 2);
        for (int i = 0; i < 3; i++) do_read(16'(2 * i));
        do_reset();
        idle(LATENCY + 2);
        do_read(16'h0010);
        idle(LATENCY + 2);
        for (int i = 0; i < 16; i++) do_write(16'(2 * i), 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2))
                0: do_write(16'($urandom_range(15) * 2), 16'($urandom));
                1: do_read(16'($urandom_range(15) * 2 + $urandom_range(1)));
                default: idle(1);
            endcase
        end
        idle(LATENCY + 3);
        check("drain", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
